// File: rtl/fp32_pkg.sv
// Shared constants, state encoding and operand classification for the FP32 accumulator.
package fp32_pkg;

  localparam int          EXP_BIAS = 127;
  localparam int          EXP_MAX  = 255;
  localparam logic [31:0] QNAN     = 32'h7FC0_0000;

  localparam int FLG_INV = 3;
  localparam int FLG_OVF = 2;
  localparam int FLG_UNF = 1;
  localparam int FLG_INX = 0;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    ADD,
    NORM,
    ROUND,
    OUT
  } state_t;

  typedef enum logic [1:0] {
    FP_ZERO,
    FP_NORMAL,
    FP_INF,
    FP_NAN
  } fpClass_t;

  // Denormals share the zero encoding because the datapath flushes them.
  function automatic fpClass_t fpClassify(input logic [31:0] word);
    if (word[30:23] == 8'd0) begin
      return FP_ZERO;
    end else if (word[30:23] == 8'hFF) begin
      return (word[22:0] == 23'd0) ? FP_INF : FP_NAN;
    end else begin
      return FP_NORMAL;
    end
  endfunction

endpackage

// File: rtl/fp32_lzc28.sv
// Combinational leading-zero counter over a 28-bit significand sum.
module fp32_lzc28 (
  input  logic [27:0] i_value,
  output logic [4:0]  o_count
);

  // Scan from the LSB upwards so the highest set bit has the final say.
  always_comb begin
    o_count = 5'd28;
    for (int i = 0; i < 28; i++) begin
      if (i_value[i]) o_count = 5'(27 - i);
    end
  end

endmodule

// File: rtl/fp32_accumulator.sv
// Multi-cycle FP32 vector reduction: each operand walks ALIGN/ADD/NORM/ROUND before the next is taken.
module fp32_accumulator
  import fp32_pkg::*;
#(
  parameter int          CNT_W    = 16,
  parameter logic [31:0] ACC_INIT = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [3:0]       out_flags,
  output logic [CNT_W-1:0] out_count
);

  state_t             r_state;
  logic [31:0]        r_acc;
  logic [3:0]         r_flags;
  logic [CNT_W-1:0]   r_count;
  logic [31:0]        r_opA;
  logic [31:0]        r_opB;
  logic               r_lastQ;
  logic               r_special;
  logic [31:0]        r_specialVal;
  logic [3:0]         r_specialFlags;
  logic               r_sign;
  logic               r_effSub;
  logic signed [9:0]  r_exp;
  logic [26:0]        r_manA;
  logic [26:0]        r_manB;
  logic [27:0]        r_sum;
  logic [26:0]        r_mant;
  logic               r_zero;

  fpClass_t           w_classA;
  fpClass_t           w_classB;
  logic               w_special;
  logic [31:0]        w_specialVal;
  logic [3:0]         w_specialFlags;
  logic [31:0]        w_big;
  logic [30:0]        w_small;
  logic [7:0]         w_expDiff;
  logic [26:0]        w_manSmall;
  logic [26:0]        w_shifted;
  logic [4:0]         w_lzc;
  logic [26:0]        w_normShifted;
  logic signed [9:0]  w_normExp;
  logic               w_roundUp;
  logic [24:0]        w_mantRnd;
  logic signed [9:0]  w_expRnd;
  logic [22:0]        w_frac;
  logic [31:0]        w_result;
  logic [3:0]         w_newFlags;

  assign in_ready = (r_state == IDLE);

  fp32_lzc28 u_lzc (
    .i_value (r_sum),
    .o_count (w_lzc)
  );

  // Resolve NaN/inf/zero operands up front so they bypass the arithmetic path.
  always_comb begin
    w_classA       = fpClassify(r_opA);
    w_classB       = fpClassify(r_opB);
    w_special      = 1'b1;
    w_specialVal   = r_opA;
    w_specialFlags = 4'd0;
    if (w_classA == FP_NAN || w_classB == FP_NAN) begin
      w_specialVal            = QNAN;
      w_specialFlags[FLG_INV] = 1'b1;
    end else if (w_classA == FP_INF && w_classB == FP_INF && (r_opA[31] != r_opB[31])) begin
      w_specialVal            = QNAN;
      w_specialFlags[FLG_INV] = 1'b1;
    end else if (w_classA == FP_INF) begin
      w_specialVal = r_opA;
    end else if (w_classB == FP_INF) begin
      w_specialVal = r_opB;
    end else if (w_classA == FP_ZERO && w_classB == FP_ZERO) begin
      w_specialVal = {r_opA[31] & r_opB[31], 31'd0};
    end else if (w_classA == FP_ZERO) begin
      w_specialVal = r_opB;
    end else if (w_classB == FP_ZERO) begin
      w_specialVal = r_opA;
    end else begin
      w_special = 1'b0;
    end
  end

  // Order by magnitude and shift the smaller significand into place, folding lost bits into sticky.
  always_comb begin
    if (r_opA[30:0] >= r_opB[30:0]) begin
      w_big   = r_opA;
      w_small = r_opB[30:0];
    end else begin
      w_big   = r_opB;
      w_small = r_opA[30:0];
    end
    w_expDiff  = w_big[30:23] - w_small[30:23];
    w_manSmall = {1'b1, w_small[22:0], 3'b000};
    if (w_expDiff >= 8'd27) begin
      w_shifted = 27'd1;
    end else begin
      w_shifted    = w_manSmall >> w_expDiff;
      w_shifted[0] = w_shifted[0] | (|(w_manSmall & ~({27{1'b1}} << w_expDiff)));
    end
  end

  // Left-normalise so the hidden bit lands back at bit 26 of the datapath.
  always_comb begin
    w_normShifted = r_sum[26:0] << (w_lzc - 5'd1);
    w_normExp     = r_exp + 10'sd1 - $signed({5'd0, w_lzc});
  end

  // Round to nearest even and map the outcome onto zero/underflow/overflow encodings.
  always_comb begin
    w_roundUp  = r_mant[2] & (r_mant[1] | r_mant[0] | r_mant[3]);
    w_mantRnd  = {1'b0, r_mant[26:3]} + {24'd0, w_roundUp};
    w_expRnd   = r_exp + $signed({9'd0, w_mantRnd[24]});
    w_frac     = w_mantRnd[24] ? w_mantRnd[23:1] : w_mantRnd[22:0];
    w_result   = {r_sign, w_expRnd[7:0], w_frac};
    w_newFlags = 4'd0;
    w_newFlags[FLG_INX] = |r_mant[2:0];
    if (r_special) begin
      w_result   = r_specialVal;
      w_newFlags = r_specialFlags;
    end else if (r_zero) begin
      w_result   = 32'd0;
      w_newFlags = 4'd0;
    end else if (r_exp <= 10'sd0) begin
      w_result            = {r_sign, 31'd0};
      w_newFlags          = 4'd0;
      w_newFlags[FLG_UNF] = 1'b1;
      w_newFlags[FLG_INX] = 1'b1;
    end else if (w_expRnd >= 10'(EXP_MAX)) begin
      w_result            = {r_sign, 8'hFF, 23'd0};
      w_newFlags          = 4'd0;
      w_newFlags[FLG_OVF] = 1'b1;
      w_newFlags[FLG_INX] = 1'b1;
    end
  end

  // Control FSM plus pipeline registers; one operand is in flight at a time.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_acc     <= ACC_INIT;
      r_flags   <= 4'd0;
      r_count   <= '0;
      out_valid <= 1'b0;
      out_data  <= 32'd0;
      out_flags <= 4'd0;
      out_count <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_opA   <= r_acc;
            r_opB   <= in_data;
            r_lastQ <= in_last;
            if (r_count != {CNT_W{1'b1}}) r_count <= r_count + 1'b1;
            r_state <= ALIGN;
          end
        end
        ALIGN: begin
          r_special      <= w_special;
          r_specialVal   <= w_specialVal;
          r_specialFlags <= w_specialFlags;
          r_sign         <= w_big[31];
          r_effSub       <= r_opA[31] ^ r_opB[31];
          r_exp          <= $signed({2'b00, w_big[30:23]});
          r_manA         <= {1'b1, w_big[22:0], 3'b000};
          r_manB         <= w_shifted;
          r_state        <= ADD;
        end
        ADD: begin
          r_sum   <= r_effSub ? ({1'b0, r_manA} - {1'b0, r_manB})
                              : ({1'b0, r_manA} + {1'b0, r_manB});
          r_state <= NORM;
        end
        NORM: begin
          r_zero <= (r_sum == 28'd0);
          if (r_sum[27]) begin
            r_mant <= {r_sum[27:2], r_sum[1] | r_sum[0]};
            r_exp  <= r_exp + 10'sd1;
          end else begin
            r_mant <= w_normShifted;
            r_exp  <= w_normExp;
          end
          r_state <= ROUND;
        end
        ROUND: begin
          r_acc   <= w_result;
          r_flags <= r_flags | w_newFlags;
          if (r_lastQ) begin
            out_valid <= 1'b1;
            out_data  <= w_result;
            out_flags <= r_flags | w_newFlags;
            out_count <= r_count;
            r_state   <= OUT;
          end else begin
            r_state <= IDLE;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            r_acc     <= ACC_INIT;
            r_flags   <= 4'd0;
            r_count   <= '0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_accumulator.sv
// Self-checking bench: directed corner cases plus random vectors against an exact-arithmetic model.
module tb_fp32_accumulator;

  localparam int TB_CNT_W = 4;

  logic                clk;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic [31:0]         in_data;
  logic                in_last;
  logic                out_valid;
  logic                out_ready;
  logic [31:0]         out_data;
  logic [3:0]          out_flags;
  logic [TB_CNT_W-1:0] out_count;

  int checks;
  int failures;

  logic [31:0]         modelAcc;
  logic [3:0]          modelFlags;
  logic [TB_CNT_W-1:0] modelCnt;

  fp32_accumulator #(
    .CNT_W    (TB_CNT_W),
    .ACC_INIT (32'h0000_0000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_flags (out_flags),
    .out_count (out_count)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic logic isNan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  function automatic logic isInf(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
  endfunction

  function automatic logic isZero(input logic [31:0] x);
    return x[30:23] == 8'd0;
  endfunction

  // Exact fixed-point value of a normal float in units of 2^-149.
  function automatic logic signed [299:0] toFixed(input logic [31:0] x);
    logic signed [299:0] m;
    m = '0;
    m[23:0] = {1'b1, x[22:0]};
    m = m << (int'(x[30:23]) - 1);
    return x[31] ? -m : m;
  endfunction

  // Reference sum: exact addition followed by a single round-to-nearest-even step.
  function automatic void refAdd(input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic [3:0] f);
    logic signed [299:0] s;
    logic [299:0] mag, rem, half, one;
    logic [24:0] mant;
    logic sign;
    int p, e, sh;
    f = 4'd0;
    if (isNan(a) || isNan(b) || (isInf(a) && isInf(b) && a[31] != b[31])) begin
      r = 32'h7FC0_0000; f[3] = 1'b1; return;
    end
    if (isInf(a)) begin r = a; return; end
    if (isInf(b)) begin r = b; return; end
    if (isZero(a) && isZero(b)) begin r = {a[31] & b[31], 31'd0}; return; end
    if (isZero(a)) begin r = b; return; end
    if (isZero(b)) begin r = a; return; end
    s = toFixed(a) + toFixed(b);
    if (s == 0) begin r = 32'd0; return; end
    sign = s < 0;
    mag  = sign ? -s : s;
    p = 0;
    for (int i = 299; i >= 0; i--) begin
      if (mag[i]) begin p = i; break; end
    end
    e = p - 22;
    if (e <= 0) begin
      r = {sign, 31'd0}; f = 4'b0011; return;
    end
    sh   = p - 23;
    one  = 300'd1;
    mant = 25'(mag >> sh);
    rem  = mag & ((one << sh) - one);
    half = (sh > 0) ? (one << (sh - 1)) : '0;
    if (rem != 0) f[0] = 1'b1;
    if (rem != 0 && (rem > half || (rem == half && mant[0]))) mant = mant + 25'd1;
    if (mant[24]) begin
      mant = mant >> 1;
      e    = e + 1;
    end
    if (e >= 255) begin
      r = {sign, 8'hFF, 23'd0}; f = 4'b0101; return;
    end
    r = {sign, 8'(e), mant[22:0]};
  endfunction

  function automatic logic [31:0] randOperand();
    int sel;
    logic [31:0] x;
    sel = $urandom_range(0, 63);
    x   = $urandom;
    case (sel)
      0:       x[30:0] = 31'd0;
      1:       x[30:23] = 8'd0;
      2:       x[30:0] = {8'hFF, 23'd0};
      3:       x[30:23] = 8'hFF;
      4, 5:    x[30:23] = 8'($urandom_range(250, 254));
      6, 7, 8: x[30:23] = 8'($urandom_range(1, 3));
      default: x[30:23] = 8'($urandom_range(110, 140));
    endcase
    if (sel == 3 && x[22:0] == 23'd0) x[22] = 1'b1;
    return x;
  endfunction

  task automatic modelReset();
    modelAcc   = 32'd0;
    modelFlags = 4'd0;
    modelCnt   = '0;
  endtask

  // Offer one operand, wait (bounded) for acceptance, return at the first negedge after the accept edge.
  task automatic applyStimulus(input logic [31:0] data, input logic last);
    int waitCycles;
    logic [31:0] r;
    logic [3:0] f;
    waitCycles = 0;
    while (!in_ready && waitCycles < 100) begin
      @(negedge clk);
      waitCycles++;
    end
    if (!in_ready) checkOutput("acceptReady", 32'(in_ready), 32'd1);
    refAdd(modelAcc, data, r, f);
    modelAcc   = r;
    modelFlags = modelFlags | f;
    if (modelCnt != {TB_CNT_W{1'b1}}) modelCnt = modelCnt + 1'b1;
    in_valid = 1'b1;
    in_data  = data;
    in_last  = last;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Wait for a result, check it, optionally stall the consumer, then complete the handshake.
  task automatic collectResult(input string tag, input logic [31:0] expData, input logic [3:0] expFlags,
                               input logic [TB_CNT_W-1:0] expCount, input int holdCycles);
    int waitCycles;
    waitCycles = 0;
    while (!out_valid && waitCycles < 60) begin
      @(negedge clk);
      waitCycles++;
    end
    checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
    checkOutput({tag, "_data"}, out_data, expData);
    checkOutput({tag, "_flags"}, 32'(out_flags), 32'(expFlags));
    checkOutput({tag, "_count"}, 32'(out_count), 32'(expCount));
    for (int i = 0; i < holdCycles; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h4040_0000;
      in_last  = 1'b1;
      @(negedge clk);
      checkOutput({tag, "_holdData"}, out_data, expData);
      checkOutput({tag, "_holdReady"}, 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput({tag, "_release"}, {30'd0, out_valid, in_ready}, 32'd1);
    modelReset();
  endtask

  // Directed scenarios first, then random vectors.
  initial begin
    logic sawReady;
    logic sawEarly;
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 32'd0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    modelReset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_outValid", 32'(out_valid), 32'd0);
    checkOutput("rst_inReady", 32'(in_ready), 32'd1);
    checkOutput("rst_outData", out_data, 32'd0);
    checkOutput("rst_outFlagsCount", {28'd0, out_flags} | 32'(out_count), 32'd0);

    applyStimulus(32'h3FC0_0000, 1'b1);
    sawReady = in_ready;
    sawEarly = out_valid;
    for (int k = 2; k <= 5; k++) begin
      @(negedge clk);
      sawReady = sawReady | in_ready;
      if (k < 5) sawEarly = sawEarly | out_valid;
    end
    checkOutput("lat_inReadyLow", 32'(sawReady), 32'd0);
    checkOutput("lat_validEarly", 32'(sawEarly), 32'd0);
    checkOutput("lat_validAt5", 32'(out_valid), 32'd1);
    collectResult("single", 32'h3FC0_0000, 4'b0000, 4'd1, 0);

    applyStimulus(32'h3F80_0000, 1'b0);
    applyStimulus(32'h4000_0000, 1'b0);
    applyStimulus(32'h4040_0000, 1'b1);
    collectResult("sum6_bp", 32'h40C0_0000, 4'b0000, 4'd3, 10);

    applyStimulus(32'h4049_0FDB, 1'b0);
    applyStimulus(32'hC049_0FDB, 1'b1);
    collectResult("cancel", 32'h0000_0000, 4'b0000, 4'd2, 0);

    applyStimulus(32'h3F80_0000, 1'b0);
    applyStimulus(32'h3380_0000, 1'b1);
    collectResult("tie", 32'h3F80_0000, 4'b0001, 4'd2, 0);

    applyStimulus(32'h7F7F_FFFF, 1'b0);
    applyStimulus(32'h7F7F_FFFF, 1'b1);
    collectResult("ovf", 32'h7F80_0000, 4'b0101, 4'd2, 0);

    applyStimulus(32'h7F80_0000, 1'b0);
    applyStimulus(32'hFF80_0000, 1'b1);
    collectResult("inv", 32'h7FC0_0000, 4'b1000, 4'd2, 0);

    applyStimulus(32'h3F80_0000, 1'b0);
    applyStimulus(32'h4040_0000, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    checkOutput("midRst_outValid", 32'(out_valid), 32'd0);
    checkOutput("midRst_inReady", 32'(in_ready), 32'd1);
    applyStimulus(32'h4000_0000, 1'b1);
    collectResult("afterRst", 32'h4000_0000, 4'b0000, 4'd1, 0);

    for (int i = 0; i < 20; i++) applyStimulus(32'h3F80_0000, i == 19);
    collectResult("countSat", 32'h41A0_0000, 4'b0000, 4'd15, 0);

    applyStimulus(32'h3F80_0000, 1'b0);
    applyStimulus(32'h4000_0000, 1'b1);
    collectResult("modelSanity", modelAcc, modelFlags, modelCnt, 0);

    for (int v = 0; v < 40; v++) begin
      int len;
      len = $urandom_range(1, 5);
      for (int e = 0; e < len; e++) applyStimulus(randOperand(), e == len - 1);
      collectResult($sformatf("rnd%0d", v), modelAcc, modelFlags, modelCnt, $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
